fetch_ctrl: RTL and testbench

Fetch-stage controller sitting directly upstream of the branch predictor. It owns the program counter and drives the synchronous instruction memory address, and it generates `save_inst_addr` for the predictor. It consumes `branch_predicted`/`branch_addr` to redirect fetch. It also tracks in-flight predicted branches in a small FIFO, compares them against execute-stage resolution, drives the predictor update (`handling_pred`, `branch_taken`) and issues mispredict flushes.

---
 rtl/fetch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// structs: shared machine-word definitions for the fetch stage.
// -----------------------------------------------------------------------------
package structs;
  localparam int word_width = 32;
  // Opcode of conditional branches (inst[6:0]).
  localparam logic [6:0] BRANCH_OP = 7'b1100011;
endpackage

// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch-stage controller. It owns the program counter and drives the
// synchronous instruction memory. It redirects on predicted-taken branches,
// tracks in-flight predicted branches in a small FIFO, compares them against
// execute-stage resolution, drives the predictor update and raises flush on
// a mispredict.
//
// Optional feature: define FETCH_PRED_STATS_EN to add the saturating
// counters stat_branches / stat_mispredicts.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   inst_addr        instruction memory address (data returns next cycle)
//   save_inst_addr   a new fetch request issues this cycle
//   inst_in          instruction returned by memory
//   branch_predicted predictor says "taken" for inst_in
//   branch_addr      predicted target
//   inst_valid       inst_in is a live instruction for decode
//   inst_pc          PC of inst_in
//   dec_ready        decode accepts the instruction this cycle
//   resolve_valid    execute resolved the oldest in-flight branch
//   resolve_taken    actual outcome
//   resolve_target   actual taken target
//   handling_pred    predictor update strobe
//   branch_taken     outcome to predictors
//   flush            mispredict; downstream squashes younger work
//   stat_branches    (FETCH_PRED_STATS_EN) resolved-branch count
//   stat_mispredicts (FETCH_PRED_STATS_EN) mispredict count
//
// Handshake: an instruction transfers to decode in a cycle where inst_valid
// and dec_ready are both high; inst_valid never depends on anything that
// decode produces other than dec_ready, and a held instruction is replayed
// from memory (inst_addr = inst_pc) until it transfers or is flushed.
// -----------------------------------------------------------------------------
module fetch_ctrl
  import structs::*;
#(
  parameter logic [word_width-1:0] RESET_PC   = '0,
  parameter int                    PRED_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [word_width-1:0] inst_addr,
  output logic                  save_inst_addr,
  input  logic [word_width-1:0] inst_in,
  input  logic                  branch_predicted,
  input  logic [word_width-1:0] branch_addr,
  output logic                  inst_valid,
  output logic [word_width-1:0] inst_pc,
  input  logic                  dec_ready,
  input  logic                  resolve_valid,
  input  logic                  resolve_taken,
  input  logic [word_width-1:0] resolve_target,
  output logic                  handling_pred,
  output logic                  branch_taken,
  output logic                  flush
`ifdef FETCH_PRED_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam int                    PW    = $clog2(PRED_DEPTH);
  localparam logic [PW:0]           FULL  = (PW + 1)'(PRED_DEPTH);
  localparam logic [word_width-1:0] INC   = word_width'(4);

  // Architectural state
  logic [word_width-1:0] pc;
  logic                  resp_valid;
  logic [word_width-1:0] resp_pc;
  logic                  fifo_taken [PRED_DEPTH];
  logic [word_width-1:0] fifo_pc    [PRED_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW:0]           count;

  // Combinational control
  logic is_br;
  logic pop;
  logic push;
  logic stall;
  logic mispredict;
  logic redirect;
  logic head_taken;
  logic [word_width-1:0] head_pc;

  logic unused_inst_bits;
  assign unused_inst_bits = ^inst_in[word_width-1:7];

  assign is_br      = (inst_in[6:0] == BRANCH_OP);
  assign head_taken = fifo_taken[rd_ptr];
  assign head_pc    = fifo_pc[rd_ptr];
  assign pop        = resolve_valid & (count != '0);
  assign mispredict = pop & (resolve_taken != head_taken);

  // A full FIFO holds only a branch, and only if no slot frees this cycle.
  assign stall = resp_valid & (~dec_ready | (is_br & (count == FULL) & ~pop));

  assign inst_valid     = resp_valid & ~stall & ~mispredict;
  assign inst_pc        = resp_pc;
  assign inst_addr      = stall ? resp_pc : pc;
  assign save_inst_addr = ~stall & ~mispredict;
  assign push           = inst_valid & is_br;
  assign redirect       = inst_valid & branch_predicted & is_br;
  assign handling_pred  = pop;
  assign branch_taken   = resolve_taken;
  assign flush          = mispredict;

  // PC, response tracking and FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      resp_valid <= 1'b0;
      resp_pc    <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (mispredict) begin
      // Everything in flight is younger than the resolved branch: drop it.
      pc         <= resolve_taken ? resolve_target : head_pc + INC;
      resp_valid <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      if (stall) begin
        // Hold pc and the outstanding response; memory replays resp_pc.
      end else if (redirect) begin
        // The sequential request issued this cycle is wrong-path.
        pc         <= branch_addr;
        resp_valid <= 1'b0;
      end else begin
        resp_valid <= 1'b1;
        resp_pc    <= inst_addr;
        pc         <= inst_addr + INC;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO payload needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push && !mispredict) begin
      fifo_taken[wr_ptr] <= branch_predicted;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

`ifdef FETCH_PRED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop && (stat_branches != '1))
        stat_branches <= stat_branches + 1'b1;
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl: directed bench for fetch_ctrl. A synchronous memory model
// returns a branch opcode at addresses listed in br_map (value = predicted
// target) and a NOP elsewhere; the predictor model reports taken for those
// addresses while pred_on is set.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
  import structs::*;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT signals
  logic [31:0] inst_addr;
  logic        save_inst_addr;
  logic [31:0] inst_in = 32'h0000_0013;
  logic        branch_predicted = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        dec_ready;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        handling_pred;
  logic        branch_taken;
  logic        flush;
`ifdef FETCH_PRED_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  fetch_ctrl #(.RESET_PC(32'h0), .PRED_DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .inst_addr        (inst_addr),
    .save_inst_addr   (save_inst_addr),
    .inst_in          (inst_in),
    .branch_predicted (branch_predicted),
    .branch_addr      (branch_addr),
    .inst_valid       (inst_valid),
    .inst_pc          (inst_pc),
    .dec_ready        (dec_ready),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .resolve_target   (resolve_target),
    .handling_pred    (handling_pred),
    .branch_taken     (branch_taken),
    .flush            (flush)
`ifdef FETCH_PRED_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // Memory + predictor model
  logic [31:0] br_map [logic [31:0]];
  bit          pred_on;

  always @(posedge clk) begin
    inst_in          <= br_map.exists(inst_addr) ? 32'h0000_0063 : 32'h0000_0013;
    branch_predicted <= pred_on && br_map.exists(inst_addr);
    branch_addr      <= br_map.exists(inst_addr) ? br_map[inst_addr] : 32'h0;
  end

  // Scoreboard counters and checker
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge; inputs set after this apply to the
  // following rising edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    dec_ready      = 1'b1;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    resolve_target = '0;
    pred_on        = 1'b1;
    br_map[32'h8]  = 32'h40;

    #1 reset = 1'b0;
    #1;
    check("rst_inst_addr",  inst_addr, 32'h0);
    check("rst_save",       {31'b0, save_inst_addr}, 32'h1);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_flush",      {31'b0, flush}, 32'h0);
    check("rst_handling",   {31'b0, handling_pred}, 32'h0);
    cyc(); cyc();

    // T0: release
    reset = 1'b1; #1;
    check("t0_addr",  inst_addr, 32'h0);
    check("t0_valid", {31'b0, inst_valid}, 32'h0);
    cyc(); #1;  // T1
    check("t1_valid", {31'b0, inst_valid}, 32'h1);
    check("t1_pc",    inst_pc, 32'h0);
    check("t1_addr",  inst_addr, 32'h4);
    cyc(); #1;  // T2
    check("t2_pc",    inst_pc, 32'h4);
    check("t2_addr",  inst_addr, 32'h8);
    cyc(); #1;  // T3: predicted-taken branch at 0x8
    check("t3_pc",    inst_pc, 32'h8);
    check("t3_addr",  inst_addr, 32'hC);
    cyc(); #1;  // T4: bubble, redirect issued
    check("t4_valid", {31'b0, inst_valid}, 32'h0);
    check("t4_addr",  inst_addr, 32'h40);
    check("t4_count", 32'(dut.count), 32'h1);
    cyc(); #1;  // T5
    check("t5_valid", {31'b0, inst_valid}, 32'h1);
    check("t5_pc",    inst_pc, 32'h40);

    // T6: branch resolves not-taken -> mispredict
    cyc();
    resolve_valid = 1'b1; resolve_taken = 1'b0; #1;
    check("t6_flush",    {31'b0, flush}, 32'h1);
    check("t6_handling", {31'b0, handling_pred}, 32'h1);
    check("t6_taken",    {31'b0, branch_taken}, 32'h0);
    check("t6_valid",    {31'b0, inst_valid}, 32'h0);
    check("t6_save",     {31'b0, save_inst_addr}, 32'h0);
    cyc();
    resolve_valid = 1'b0; #1;  // T7
    check("t7_addr",  inst_addr, 32'hC);
    check("t7_count", 32'(dut.count), 32'h0);
    check("t7_valid", {31'b0, inst_valid}, 32'h0);
    check("t7_flush", {31'b0, flush}, 32'h0);
    cyc(); #1;  // T8
    check("t8_valid", {31'b0, inst_valid}, 32'h1);
    check("t8_pc",    inst_pc, 32'hC);

    // T9..T11: decode back-pressure at 0x10
    cyc();
    dec_ready = 1'b0;
    pred_on   = 1'b0;
    for (int a = 32'h18; a <= 32'h28; a += 4) br_map[32'(a)] = 32'h200;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin cyc(); #1; end
      check("stall_addr",  inst_addr, 32'h10);
      check("stall_save",  {31'b0, save_inst_addr}, 32'h0);
      check("stall_valid", {31'b0, inst_valid}, 32'h0);
    end
    cyc();
    dec_ready = 1'b1; #1;  // T12
    check("t12_valid", {31'b0, inst_valid}, 32'h1);
    check("t12_pc",    inst_pc, 32'h10);
    check("t12_addr",  inst_addr, 32'h14);
    cyc(); #1;  // T13
    check("t13_pc", inst_pc, 32'h14);

    // T14..T17: four not-taken-predicted branches fill the FIFO
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      check("fill_pc",    inst_pc, 32'(32'h18 + 4 * i));
      check("fill_valid", {31'b0, inst_valid}, 32'h1);
    end
    // T18, T19: fifth branch held
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      check("full_valid", {31'b0, inst_valid}, 32'h0);
      check("full_addr",  inst_addr, 32'h28);
      check("full_count", 32'(dut.count), 32'h4);
    end
    // T20: correct resolve frees a slot; held branch delivered same cycle
    cyc();
    resolve_valid = 1'b1; resolve_taken = 1'b0; #1;
    check("t20_valid",    {31'b0, inst_valid}, 32'h1);
    check("t20_pc",       inst_pc, 32'h28);
    check("t20_handling", {31'b0, handling_pred}, 32'h1);
    check("t20_flush",    {31'b0, flush}, 32'h0);
    cyc();
    resolve_valid = 1'b0; #1;  // T21
    check("t21_pc",    inst_pc, 32'h2C);
    check("t21_count", 32'(dut.count), 32'h4);
    // T22, T23: two more correct resolves
    for (int i = 0; i < 2; i++) begin
      cyc();
      resolve_valid = 1'b1; resolve_taken = 1'b0; #1;
      check("drain_flush", {31'b0, flush}, 32'h0);
      check("drain_pc",    inst_pc, 32'(32'h30 + 4 * i));
    end
    // T24: head predicted not-taken, actually taken to 0x100
    cyc();
    resolve_taken = 1'b1; resolve_target = 32'h100; #1;
    check("t24_flush", {31'b0, flush}, 32'h1);
    check("t24_taken", {31'b0, branch_taken}, 32'h1);
    cyc();
    resolve_valid = 1'b0; #1;  // T25
    check("t25_addr",  inst_addr, 32'h100);
    check("t25_count", 32'(dut.count), 32'h0);
    check("t25_valid", {31'b0, inst_valid}, 32'h0);
    // T26: resolve with empty FIFO is ignored
    cyc();
    resolve_valid = 1'b1; resolve_taken = 1'b1; #1;
    check("t26_handling", {31'b0, handling_pred}, 32'h0);
    check("t26_flush",    {31'b0, flush}, 32'h0);
    check("t26_valid",    {31'b0, inst_valid}, 32'h1);
    check("t26_pc",       inst_pc, 32'h100);
`ifdef FETCH_PRED_STATS_EN
    cyc();
    resolve_valid = 1'b0; #1;
    check("stat_branches",    stat_branches, 32'd5);
    check("stat_mispredicts", stat_mispredicts, 32'd2);
`else
    cyc();
    resolve_valid = 1'b0; #1;
`endif

    // Asynchronous reset mid-operation
    #3 reset = 1'b0; #1;
    check("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
    check("mid_rst_addr",  inst_addr, 32'h0);
    check("mid_rst_count", 32'(dut.count), 32'h0);
    cyc();
    reset = 1'b1; #1;
    check("rel_addr", inst_addr, 32'h0);
    cyc(); #1;
    check("rel_valid", {31'b0, inst_valid}, 32'h1);
    check("rel_pc",    inst_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
